// File: rtl/param_unpack_pkg.sv
// Shared types and helpers for the wide-to-narrow word unpacker.
package param_unpack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_beat_counter.sv
// Beat index counter: loads 0, increments on each sent beat, wraps after MAX-1.
module param_beat_counter
  import param_unpack_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned CW = clog2(MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == CW'(MAX - 1));
  assign count  = r_count;
  assign wrap   = w_wrap;

  // Load takes priority so a same-cycle reload restarts at beat 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/param_unpacker.sv
// Splits each accepted IN_W word into IN_W/OUT_W beats of OUT_W bits.
module param_unpacker
  import param_unpack_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned CW    = clog2(RATIO);

  generate
    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("param_unpacker: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
  endgenerate

  state_t            r_state;
  logic [IN_W-1:0]   r_hold;
  logic              r_hold_last;
  logic              r_m_valid;
  logic [OUT_W-1:0]  r_m_data;
  logic              r_m_last;

  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_cnt_next;
  logic              w_cnt_wrap;
  logic              w_in_xfer;
  logic              w_out_xfer;

  // Select beat k of a word in the configured emission order.
  function automatic logic [OUT_W-1:0] f_beat(input logic [IN_W-1:0] w,
                                              input logic [CW-1:0]   k);
    int unsigned pos;
    pos = MSB_FIRST ? (RATIO - 1 - 32'(k)) : 32'(k);
    return OUT_W'(w >> (pos * OUT_W));
  endfunction

  // Ready when idle, or when the final beat leaves this cycle.
  assign s_ready    = rst_n && ((r_state == IDLE) || (w_cnt_wrap && m_ready));
  assign w_in_xfer  = s_valid && s_ready;
  assign w_out_xfer = r_m_valid && m_ready;
  assign w_cnt_next = w_cnt + CW'(1);

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign busy    = (r_state == SEND);

  param_beat_counter #(
    .MAX (RATIO)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_in_xfer),
    .inc   (w_out_xfer),
    .count (w_cnt),
    .wrap  (w_cnt_wrap)
  );

  // FSM plus registered beat outputs; the next beat is prepared on each
  // transfer so m_data is a plain register rather than a mux of the hold word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
    end else if (w_in_xfer) begin
      r_state     <= SEND;
      r_hold      <= s_data;
      r_hold_last <= s_last;
      r_m_valid   <= 1'b1;
      r_m_data    <= f_beat(s_data, '0);
      r_m_last    <= 1'b0;  // beat 0 is never the final beat (RATIO >= 2)
    end else if (w_out_xfer) begin
      if (w_cnt_wrap) begin
        r_state   <= IDLE;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else begin
        r_m_data  <= f_beat(r_hold, w_cnt_next);
        r_m_last  <= r_hold_last && (w_cnt_next == CW'(RATIO - 1));
      end
    end
  end

endmodule

// File: tb/tb_param_unpacker.sv
// Scoreboard bench: two unpackers (MSB-first and LSB-first) share one stimulus.
module tb_param_unpacker;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned RATIO = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic [IN_W-1:0]  s_data = '0;
  logic             s_last = 1'b0;
  logic             m_ready = 1'b0;

  logic             s_ready_a, m_valid_a, m_last_a, busy_a;
  logic [OUT_W-1:0] m_data_a;
  logic             s_ready_b, m_valid_b, m_last_b, busy_b;
  logic [OUT_W-1:0] m_data_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             l;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  always #5 clk = ~clk;

  param_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_data(m_data_a), .m_last(m_last_a), .busy(busy_a)
  );

  param_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_data(m_data_b), .m_last(m_last_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the reference decides acceptance from the
  // number of beats still owed and the downstream ready.
  task automatic drive_cycle(input logic v, input logic [IN_W-1:0] d, input logic l,
                             input logic mr, input logic rn, output logic acc);
    logic exp_ready;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; m_ready = mr; rst_n = rn;
    #1;
    exp_ready = rn && ((qa.size() == 0) || (qa.size() == 1 && mr));
    check("s_ready_a", s_ready_a, exp_ready);
    check("s_ready_b", s_ready_b, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (!rn) begin
      qa.delete();
      qb.delete();
    end else if (acc) begin
      for (int k = 0; k < RATIO; k++) begin
        beat_t e;
        e.l = l && (k == RATIO - 1);
        e.d = OUT_W'(d >> (OUT_W * (RATIO - 1 - k)));
        qa.push_back(e);
        e.d = OUT_W'(d >> (OUT_W * k));
        qb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic mr);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, mr, 1'b1, acc);
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 12 && !acc; t++) drive_cycle(1'b1, d, l, 1'b1, 1'b1, acc);
    check("accept_timeout", acc, 1'b1);
  endtask

  // Monitor: pops and compares whenever a beat is transferred.
  initial begin
    beat_t e;
    logic stall_a, stall_b, hl_a, hl_b;
    logic [OUT_W-1:0] hd_a, hd_b;
    stall_a = 1'b0; stall_b = 1'b0; hl_a = 1'b0; hl_b = 1'b0; hd_a = '0; hd_b = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_a = 1'b0;
        stall_b = 1'b0;
      end else begin
        check("m_valid_a", m_valid_a, qa.size() != 0);
        check("busy_a", busy_a, qa.size() != 0);
        check("m_valid_b", m_valid_b, qb.size() != 0);
        check("busy_b", busy_b, qb.size() != 0);
        if (stall_a) begin
          check("stall_data_a", m_data_a, hd_a);
          check("stall_last_a", m_last_a, hl_a);
        end
        if (stall_b) begin
          check("stall_data_b", m_data_b, hd_b);
          check("stall_last_b", m_last_b, hl_b);
        end
        if (m_valid_a && m_ready && qa.size() != 0) begin
          e = qa.pop_front();
          check("beat_data_a", m_data_a, e.d);
          check("beat_last_a", m_last_a, e.l);
        end
        if (m_valid_b && m_ready && qb.size() != 0) begin
          e = qb.pop_front();
          check("beat_data_b", m_data_b, e.d);
          check("beat_last_b", m_last_b, e.l);
        end
        stall_a = m_valid_a && !m_ready; hd_a = m_data_a; hl_a = m_last_a;
        stall_b = m_valid_b && !m_ready; hd_b = m_data_b; hl_b = m_last_b;
      end
    end
  end

  initial begin
    logic acc;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    #1;
    check("rst_m_valid_a", m_valid_a, 1'b0);
    check("rst_m_data_a", m_data_a, 8'h00);
    check("rst_m_data_b", m_data_b, 8'h00);
    check("rst_m_last_a", m_last_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_s_ready_a", s_ready_a, 1'b0);
    idle(2, 1'b1);

    // Single words in both orders, with and without s_last.
    send_word(32'hAABBCCDD, 1'b0);
    idle(6, 1'b1);
    send_word(32'hAABBCCDD, 1'b1);
    idle(6, 1'b1);

    // Back-to-back words with s_valid and m_ready held high.
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b1);
    idle(6, 1'b1);

    // Downstream stall while beat 1 is presented.
    send_word(32'hAABBCCDD, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Reset right after beat 0 has transferred.
    send_word(32'hAABBCCDD, 1'b1);
    idle(1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    idle(6, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 9) < 6, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0, acc);
    end

    for (int i = 0; i < 20 && qa.size() != 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    check("drain_empty_a", qa.size(), 0);
    check("drain_empty_b", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
